fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined core. It generalises rs1/rs2 EX/MEM + MEM/WB forwarding to NUM_SRC source operands and NUM_FWD forwarding stages. It adds load-use stall detection and a per-register latency scoreboard for multi-cycle ops (mul/div). It sits beside the ID/EX register and drives the ALU operand muxes and the pipeline stall line.

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_hazard_unit_lat_scoreboard.sv | 50 +++++
 rtl/fwd_hazard_unit.sv | 87 ++++++++
 tb/tb_fwd_hazard_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding/hazard unit and its scoreboard.
package fwd_pkg;

    localparam int FWD_SEL_REGFILE = 0;
    localparam int REG_ZERO        = 0;

    localparam int DEF_NUM_SRC     = 2;
    localparam int DEF_NUM_FWD     = 2;
    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_MAX_LAT     = 15;
    localparam int DEF_STALL_CNT_W = 16;

    // One select code per forwarding stage plus the register-file code.
    function automatic int fwd_sel_width(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_lat_scoreboard.sv
// Per-register latency scoreboard: one down-counter per register, busy while nonzero.
module lat_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LAT_W      = $clog2(DEF_MAX_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_rd,
    input  logic [LAT_W-1:0]           issue_lat,
    input  logic                       flush,
    output logic [(2**REG_ADDR_W)-1:0] busy_vec
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic             load;

    // Zero latency or a write to r0 never creates a pending result.
    assign load = issue_valid
                  && (issue_rd != REG_ADDR_W'(REG_ZERO))
                  && (issue_lat != '0);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (load && (issue_rd == REG_ADDR_W'(r))) begin
                    cnt[r] <= issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / multi-cycle stall detection and stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int NUM_FWD     = DEF_NUM_FWD,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MAX_LAT     = DEF_MAX_LAT,
    parameter int LAT_W       = $clog2(MAX_LAT + 1),
    parameter int SEL_W       = fwd_sel_width(NUM_FWD),
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_FWD-1:0]            fwd_wr_en,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_data_ready,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic [LAT_W-1:0]              issue_lat,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [(2**REG_ADDR_W)-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    logic [NUM_SRC-1:0] hazard;

    lat_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .LAT_W      (LAT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .busy_vec    (busy_vec)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_ADDR_W-1:0] addr;
        logic                  active;
        logic                  sb_hz;
        logic                  fwd_hz;
        logic [SEL_W-1:0]      fsel;

        assign addr   = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
        assign active = src_valid[i] && (addr != REG_ADDR_W'(REG_ZERO));
        assign sb_hz  = active && (busy_vec[addr] || (issue_valid && (issue_rd == addr)));

        // Walk oldest to youngest so the youngest matching stage has the last word.
        always_comb begin
            fsel   = SEL_W'(FWD_SEL_REGFILE);
            fwd_hz = 1'b0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (active && fwd_wr_en[k] && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                    if (fwd_data_ready[k]) begin
                        fsel   = SEL_W'(k + 1);
                        fwd_hz = 1'b0;
                    end else begin
                        fsel   = SEL_W'(FWD_SEL_REGFILE);
                        fwd_hz = 1'b1;
                    end
                end
            end
        end

        assign hazard[i] = sb_hz || fwd_hz;
        assign fwd_sel[i*SEL_W +: SEL_W] = (flush || sb_hz) ? SEL_W'(FWD_SEL_REGFILE) : fsel;
    end

    assign stall = (|hazard) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a cycle-indexed reference model.
module tb_fwd_hazard_unit;

    localparam int NS = 2;
    localparam int NF = 2;
    localparam int AW = 5;
    localparam int LW = 4;
    localparam int SW = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_valid;
    logic [NS*AW-1:0]  src_addr;
    logic [NF-1:0]     fwd_wr_en;
    logic [NF*AW-1:0]  fwd_rd;
    logic [NF-1:0]     fwd_data_ready;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [LW-1:0]     issue_lat;
    logic              flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic [31:0]       busy_vec;
    logic [CW-1:0]     stall_cycles;

    fwd_hazard_unit #(
        .NUM_SRC     (NS),
        .NUM_FWD     (NF),
        .REG_ADDR_W  (AW),
        .MAX_LAT     (15),
        .STALL_CNT_W (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid      (src_valid),
        .src_addr       (src_addr),
        .fwd_wr_en      (fwd_wr_en),
        .fwd_rd         (fwd_rd),
        .fwd_data_ready (fwd_data_ready),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .busy_vec       (busy_vec),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each register remembers the last cycle it is still pending.
    int busy_until [32];
    int cyc_n    = 0;
    int m_sc     = 0;
    bit model_ok = 1'b0;

    function automatic bit is_busy(input int r);
        return cyc_n <= busy_until[r];
    endfunction

    function automatic void model_op(input int i, output int sel, output bit hz);
        int addr;
        addr = int'(src_addr[i*AW +: AW]);
        sel  = 0;
        hz   = 1'b0;
        if (flush || !src_valid[i] || addr == 0) return;
        if (is_busy(addr) || (issue_valid && int'(issue_rd) == addr)) begin
            hz = 1'b1;
            return;
        end
        for (int k = 0; k < NF; k++) begin
            if (fwd_wr_en[k] && int'(fwd_rd[k*AW +: AW]) == addr) begin
                if (fwd_data_ready[k]) sel = k + 1;
                else                   hz  = 1'b1;
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        int s;
        bit h;
        bit any;
        any = 1'b0;
        for (int i = 0; i < NS; i++) begin
            model_op(i, s, h);
            any = any | h;
        end
        return any;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) busy_until[r] = -1;
            m_sc     = 0;
            model_ok = 1'b1;
        end else begin
            if (model_stall() && m_sc < 15) m_sc++;
            if (flush) begin
                for (int r = 0; r < 32; r++) busy_until[r] = -1;
            end else if (issue_valid && issue_rd != 0 && issue_lat != 0) begin
                busy_until[issue_rd] = cyc_n + int'(issue_lat);
            end
        end
        cyc_n++;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            int  s;
            bit  h;
            logic [31:0] eb;
            for (int i = 0; i < NS; i++) begin
                model_op(i, s, h);
                check($sformatf("model_sel%0d", i), fwd_sel[i*SW +: SW], s);
            end
            check("model_stall", stall, model_stall());
            eb = '0;
            for (int r = 0; r < 32; r++) eb[r] = is_busy(r);
            check("model_busy", busy_vec, eb);
            check("model_stall_cycles", stall_cycles, m_sc);
        end
    end

    task automatic idle();
        src_valid      = '0;
        src_addr       = '0;
        fwd_wr_en      = '0;
        fwd_rd         = '0;
        fwd_data_ready = '0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_lat      = '0;
        flush          = 1'b0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_use();
        src_valid      = 2'b10;
        src_addr[9:5]  = 5'd7;
        fwd_wr_en      = 2'b11;
        fwd_rd[4:0]    = 5'd7;
        fwd_rd[9:5]    = 5'd7;
        fwd_data_ready = 2'b10;
    endtask

    initial begin
        // Reset held two edges while an issue is presented
        rst_n       = 1'b0;
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        issue_lat   = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        check("rst_busy", busy_vec, 0);
        check("rst_stall", stall, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_fwd_sel", fwd_sel, 0);

        // Youngest stage wins when both match
        go();
        src_valid      = 2'b01;
        src_addr[4:0]  = 5'd5;
        fwd_wr_en      = 2'b11;
        fwd_rd[4:0]    = 5'd5;
        fwd_rd[9:5]    = 5'd5;
        fwd_data_ready = 2'b11;
        @(negedge clk);
        check("prio_sel0", fwd_sel[1:0], 1);

        go();
        src_valid      = 2'b01;
        src_addr[4:0]  = 5'd0;
        fwd_wr_en      = 2'b11;
        fwd_rd[4:0]    = 5'd0;
        fwd_rd[9:5]    = 5'd5;
        fwd_data_ready = 2'b11;
        @(negedge clk);
        check("r0_sel0", fwd_sel[1:0], 0);
        check("r0_stall", stall, 0);

        go();
        src_valid      = 2'b01;
        src_addr[4:0]  = 5'd5;
        fwd_wr_en      = 2'b11;
        fwd_rd[4:0]    = 5'd0;
        fwd_rd[9:5]    = 5'd5;
        fwd_data_ready = 2'b11;
        @(negedge clk);
        check("older_sel0", fwd_sel[1:0], 2);

        // Load-use: youngest match not ready, no fall-through
        go();
        load_use();
        @(negedge clk);
        check("lu_stall", stall, 1);
        check("lu_sel1", fwd_sel[3:2], 0);
        check("lu_cnt0", stall_cycles, 0);

        go();
        load_use();
        fwd_data_ready = 2'b11;
        @(negedge clk);
        check("lu_ready_stall", stall, 0);
        check("lu_ready_sel1", fwd_sel[3:2], 1);
        check("lu_cnt1", stall_cycles, 1);

        // Multi-cycle latency: issue r3 lat 4 while operand 0 reads r3
        go();
        src_valid     = 2'b01;
        src_addr[4:0] = 5'd3;
        issue_valid   = 1'b1;
        issue_rd      = 5'd3;
        issue_lat     = 4'd4;
        @(negedge clk);
        check("lat_stall_t0", stall, 1);
        check("lat_busy_t0", busy_vec[3], 0);
        for (int c = 1; c <= 5; c++) begin
            go();
            src_valid     = 2'b01;
            src_addr[4:0] = 5'd3;
            if (c == 1) begin
                fwd_wr_en      = 2'b01;
                fwd_rd[4:0]    = 5'd3;
                fwd_data_ready = 2'b01;
            end
            @(negedge clk);
            check($sformatf("lat_stall_t%0d", c), stall, c <= 4);
            check($sformatf("lat_busy_t%0d", c), busy_vec[3], c <= 4);
            check($sformatf("lat_sel_t%0d", c), fwd_sel[1:0], 0);
        end
        check("lat_cnt", stall_cycles, 6);

        // Re-issue overwrites the pending latency
        go();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        issue_lat   = 4'd6;
        @(negedge clk);
        go();
        @(negedge clk);
        go();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        issue_lat   = 4'd2;
        @(negedge clk);
        check("ovr_busy_t2", busy_vec[3], 1);
        for (int c = 3; c <= 6; c++) begin
            go();
            @(negedge clk);
            check($sformatf("ovr_busy_t%0d", c), busy_vec[3], c <= 4);
        end

        // Flush kills tracked ops and a same-cycle issue
        go();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        issue_lat   = 4'd8;
        @(negedge clk);
        repeat (2) begin
            go();
            @(negedge clk);
        end
        go();
        flush          = 1'b1;
        src_valid      = 2'b11;
        src_addr[4:0]  = 5'd9;
        src_addr[9:5]  = 5'd12;
        fwd_wr_en      = 2'b10;
        fwd_rd[9:5]    = 5'd12;
        fwd_data_ready = 2'b10;
        issue_valid    = 1'b1;
        issue_rd       = 5'd10;
        issue_lat      = 4'd5;
        @(negedge clk);
        check("fl_stall", stall, 0);
        check("fl_sel", fwd_sel, 0);
        check("fl_busy9_during", busy_vec[9], 1);
        go();
        @(negedge clk);
        check("fl_busy_after", busy_vec, 0);
        go();
        @(negedge clk);
        check("fl_busy_after2", busy_vec, 0);

        // Stall counter saturates without wrapping
        repeat (20) begin
            go();
            load_use();
            @(negedge clk);
        end
        go();
        @(negedge clk);
        check("sat_cnt", stall_cycles, 15);

        // Only reset clears the counter
        go();
        rst_n = 1'b0;
        @(negedge clk);
        go();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_cnt", stall_cycles, 0);
        check("rst2_busy", busy_vec, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
